// File: rtl/axi_burst_arbiter.sv
// Two-port round-robin arbiter/sequencer for the AXI burst master: grants one
// requester, launches its burst, watches the channel handshakes and returns status.
module axi_burst_arbiter #(
   parameter int TIMEOUT = 1023
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   input  logic         req1_valid,
   input  logic         req0_write,
   input  logic         req1_write,
   input  logic [15:0]  req0_cmd,
   input  logic [15:0]  req1_cmd,
   input  logic [127:0] req0_wdata,
   input  logic [127:0] req1_wdata,
   output logic         req0_ready,
   output logic         req1_ready,
   output logic         done0,
   output logic         done1,
   output logic         done_err,
   output logic [4:0]   done_beats,
   output logic         rd_beat_valid,
   output logic [7:0]   rd_beat_data,
   output logic         rd_beat_owner,
   output logic         busy,
   output logic         en,
   output logic         en_,
   output logic [15:0]  tb_R,
   output logic [15:0]  tb_W,
   output logic [127:0] INDATA,
   input  logic         rvalid,
   input  logic         rready,
   input  logic         rlast,
   input  logic [7:0]   rdata,
   input  logic         bvalid,
   input  logic         bready,
   input  logic [4:0]   bresp
);

   typedef enum logic [2:0] {S_IDLE, S_GRANT, S_LAUNCH, S_WAIT, S_DONE} state_t;

   // Last WAIT cycle index (counter value) before a forced timeout completion.
   localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

   state_t        state;
   logic          last;
   logic          owner;
   logic          is_write;
   logic [9:0]    tcnt;
   logic [4:0]    beats;

   logic          win;
   logic          sel_wr;
   logic [15:0]   sel_cmd;
   logic [127:0]  sel_data;
   logic          rd_hs;
   logic [4:0]    beats_nxt;
   logic          cmpl;
   logic          tmo;

   function automatic logic [4:0] sat_inc(input logic [4:0] v);
      return (v == 5'd31) ? v : v + 5'd1;
   endfunction

   always_comb begin
      win       = (req0_valid & req1_valid) ? ~last : req1_valid;
      sel_wr    = win ? req1_write : req0_write;
      sel_cmd   = win ? req1_cmd   : req0_cmd;
      sel_data  = win ? req1_wdata : req0_wdata;
      rd_hs     = rvalid & rready & ~is_write;
      beats_nxt = rd_hs ? sat_inc(beats) : beats;
      cmpl      = is_write ? (bvalid & bready) : (rd_hs & rlast);
      tmo       = (tcnt == TO_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         last          <= 1'b1;
         owner         <= 1'b0;
         is_write      <= 1'b0;
         tcnt          <= '0;
         beats         <= '0;
         req0_ready    <= 1'b0;
         req1_ready    <= 1'b0;
         done0         <= 1'b0;
         done1         <= 1'b0;
         done_err      <= 1'b0;
         done_beats    <= '0;
         rd_beat_valid <= 1'b0;
         rd_beat_data  <= '0;
         rd_beat_owner <= 1'b0;
         busy          <= 1'b0;
         en            <= 1'b0;
         en_           <= 1'b0;
         tb_R          <= '0;
         tb_W          <= '0;
         INDATA        <= '0;
      end else begin
         req0_ready    <= 1'b0;
         req1_ready    <= 1'b0;
         done0         <= 1'b0;
         done1         <= 1'b0;
         rd_beat_valid <= 1'b0;
         en            <= 1'b0;
         en_           <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req0_valid | req1_valid) begin
                  state         <= S_GRANT;
                  busy          <= 1'b1;
                  owner         <= win;
                  rd_beat_owner <= win;
                  req0_ready    <= ~win;
                  req1_ready    <= win;
                  is_write      <= sel_wr;
                  tb_R          <= sel_wr ? 16'd0 : sel_cmd;
                  tb_W          <= sel_wr ? sel_cmd : 16'd0;
                  INDATA        <= sel_wr ? sel_data : 128'd0;
               end
            end
            S_GRANT: begin
               state <= S_LAUNCH;
               en    <= ~is_write;
               en_   <= is_write;
            end
            S_LAUNCH: begin
               state <= S_WAIT;
               tcnt  <= '0;
               beats <= '0;
            end
            S_WAIT: begin
               tcnt <= tcnt + 10'd1;
               if (rd_hs) begin
                  beats         <= beats_nxt;
                  rd_beat_valid <= 1'b1;
                  rd_beat_data  <= rdata;
               end
               // A completion on the timeout cycle still reports normal status.
               if (cmpl || tmo) begin
                  state      <= S_DONE;
                  done0      <= ~owner;
                  done1      <= owner;
                  done_beats <= beats_nxt;
                  done_err   <= cmpl ? (is_write & (bresp != 5'd0)) : 1'b1;
               end
            end
            S_DONE: begin
               state      <= S_IDLE;
               busy       <= 1'b0;
               last       <= owner;
               done_err   <= 1'b0;
               done_beats <= '0;
               tb_R       <= '0;
               tb_W       <= '0;
               INDATA     <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
